// File: rtl/cpu_trace_pkg.sv
// Shared constants, types and helpers for the CPU trace capture block.
// A record is 5 bytes: pc, instruction, alu_result, out_val, {marker, flags}.
package cpu_trace_pkg;

    localparam int         REC_BYTES = 5;
    localparam int         REC_W     = 40;
    localparam logic [3:0] MARKER    = 4'hA;

    localparam logic [2:0] IDX_FIRST = 3'd0;
    localparam logic [2:0] IDX_LAST  = 3'(REC_BYTES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_e;

    // Byte 0 sits in the most significant position so records read in capture order.
    function automatic logic [7:0] rec_byte(input logic [REC_W-1:0] rec, input logic [2:0] idx);
        case (idx)
            3'd0:    rec_byte = rec[39:32];
            3'd1:    rec_byte = rec[31:24];
            3'd2:    rec_byte = rec[23:16];
            3'd3:    rec_byte = rec[15:8];
            default: rec_byte = rec[7:0];
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous record FIFO with combinational head read and a registered level count.
// Pointers carry one extra wrap bit to distinguish full from empty.
module trace_fifo
    import cpu_trace_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  W     = REC_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic [AW:0]  r_level;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_level = r_level;

endmodule

// File: rtl/cpu_trace_capture.sv
// Passive CPU trace tap: captures a record on every new pc, queues it, and
// serializes queued records as a valid/ready byte stream. Never stalls the CPU.
module cpu_trace_capture
    import cpu_trace_pkg::*;
#(
    parameter int  DEPTH  = 8,
    parameter int  DROP_W = 8,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_en,
    input  logic [7:0]        pc,
    input  logic [7:0]        instruction,
    input  logic [7:0]        alu_result,
    input  logic [7:0]        out_val,
    input  logic              zero_flag,
    input  logic              neg_flag,
    output logic [7:0]        m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count,
    output logic [LW-1:0]     level
);

    logic [7:0]        r_last_pc;
    logic              r_have_last;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;
    ser_state_e        r_state;
    ser_state_e        w_state_next;
    logic [REC_W-1:0]  r_rec;
    logic [2:0]        r_idx;
    logic              r_valid;

    logic              w_cap;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_xfer;
    logic              w_full;
    logic              w_empty;
    logic [REC_W-1:0]  w_wdata;
    logic [REC_W-1:0]  w_head;

    assign w_cap   = cap_en && (!r_have_last || (pc != r_last_pc));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_cap && (!w_full || w_pop);
    assign w_drop  = w_cap && !w_push;
    assign w_xfer  = r_valid && m_ready;
    assign w_wdata = {pc, instruction, alu_result, out_val, MARKER, 2'b00, neg_flag, zero_flag};

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_pc    <= '0;
            r_have_last  <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_have_last <= cap_en;
            if (cap_en) begin
                r_last_pc <= pc;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_xfer && (r_idx == IDX_LAST)) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // A pop from IDLE loads the record; byte0 is presented from the following cycle.
    // A pop at the end of a record chains straight into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rec   <= '0;
            r_idx   <= IDX_FIRST;
            r_valid <= 1'b0;
        end else if (w_pop) begin
            r_rec   <= w_head;
            r_idx   <= IDX_FIRST;
            r_valid <= (r_state == SEND);
        end else if ((r_state == SEND) && !r_valid) begin
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            if (r_idx == IDX_LAST) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    always_comb begin
        m_valid    = r_valid;
        m_last     = r_valid && (r_idx == IDX_LAST);
        m_data     = rec_byte(r_rec, r_idx);
        overflow   = r_overflow;
        drop_count = r_drop_count;
    end

endmodule
